// File: rtl/texel_promote_arbiter.sv
// Texel promotion arbiter: two texture samplers share one RGBA5652 -> Q4.12
// promotion datapath. Round-robin grant, locked while the output is stalled,
// one registered output stage tagged with source and request tag, plus
// wrapping per-requester accept counters for performance debug.

package fp_types_pkg;

    // Each channel is widened to 12 bits by bit replication (0 -> 0x000,
    // full scale -> 0xFFF), then its MSB is added so full scale lands on
    // exactly 0x1000 (1.0 in Q4.12) while zero stays at 0x0000.
    function automatic logic [15:0] promote_r5_to_q412(input logic [4:0] x);
        logic [11:0] rep;
        rep = {x, x, x[4:3]};
        return {4'd0, rep} + {15'd0, x[4]};
    endfunction

    function automatic logic [15:0] promote_g6_to_q412(input logic [5:0] x);
        logic [11:0] rep;
        rep = {x, x};
        return {4'd0, rep} + {15'd0, x[5]};
    endfunction

    function automatic logic [15:0] promote_b5_to_q412(input logic [4:0] x);
        logic [11:0] rep;
        rep = {x, x, x[4:3]};
        return {4'd0, rep} + {15'd0, x[4]};
    endfunction

    function automatic logic [15:0] promote_a2_to_q412(input logic [1:0] x);
        logic [11:0] rep;
        rep = {6{x}};
        return {4'd0, rep} + {15'd0, x[1]};
    endfunction

endpackage

module texel_promote_arbiter
    import fp_types_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [17:0]      req0_texel,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [17:0]      req1_texel,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      out_r_q412,
    output logic [15:0]      out_g_q412,
    output logic [15:0]      out_b_q412,
    output logic [15:0]      out_a_q412,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             can_accept;
    logic             grant_valid;
    logic             grant_id;
    logic             xfer;
    logic             rr_last;
    logic             lock_valid;
    logic             lock_id;
    logic [17:0]      sel_texel;
    logic [TAG_W-1:0] sel_tag;
    logic [15:0]      prom_r;
    logic [15:0]      prom_g;
    logic [15:0]      prom_b;
    logic [15:0]      prom_a;

    // The output register can take a new texel when empty or being drained.
    assign can_accept = !out_valid || out_ready;

    // Grant selection: a held lock wins; otherwise round-robin on contention.
    // Deliberately independent of out_ready so no combinational loop forms.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (lock_valid) begin
            grant_valid = 1'b1;
            grant_id    = lock_id;
        end else if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~rr_last;
        end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    // rst_n gating keeps both ready lines low for the whole reset window.
    assign req0_ready = grant_valid && !grant_id && can_accept && rst_n;
    assign req1_ready = grant_valid &&  grant_id && can_accept && rst_n;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Mux the granted requester into the shared promotion datapath.
    always_comb begin
        sel_texel = grant_id ? req1_texel : req0_texel;
        sel_tag   = grant_id ? req1_tag   : req0_tag;
        prom_r    = promote_r5_to_q412(sel_texel[17:13]);
        prom_g    = promote_g6_to_q412(sel_texel[12:7]);
        prom_b    = promote_b5_to_q412(sel_texel[6:2]);
        prom_a    = promote_a2_to_q412(sel_texel[1:0]);
    end

    // Output stage: load on transfer, drain when consumed, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_src    <= 1'b0;
            out_tag    <= '0;
            out_r_q412 <= '0;
            out_g_q412 <= '0;
            out_b_q412 <= '0;
            out_a_q412 <= '0;
        end else if (xfer) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            out_valid  <= 1'b1;
            out_src    <= grant_id;
            out_tag    <= sel_tag;
            out_r_q412 <= prom_r;
            out_g_q412 <= prom_g;
            out_b_q412 <= prom_b;
            out_a_q412 <= prom_a;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Arbitration state: round-robin pointer and stall lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last    <= 1'b1;
            lock_valid <= 1'b0;
            lock_id    <= 1'b0;
        end else if (xfer) begin
            rr_last    <= grant_id;
            lock_valid <= 1'b0;
        end else if (grant_valid && !can_accept) begin
            lock_valid <= 1'b1;
            lock_id    <= grant_id;
        end
    end

    // Per-requester accept counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (req0_valid && req0_ready) cnt0 <= cnt0 + CNT_W'(1);
            if (req1_valid && req1_ready) cnt1 <= cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: doc/texel_promote_arbiter.md
Name: texel_promote_arbiter

Overview:
Shares one RGBA5652→Q4.12 promotion datapath between two texture sampler requesters (TEX0, TEX1) in the pixel pipeline, Stage 3 of UNIT-006. It uses round-robin arbitration with grant locking during stalls. It has a single registered output stage carrying source ID and tag, so downstream combiners can route results. It also keeps per-requester accept counters for performance debug.

Parameters:
TAG_W, 4, width of opaque per-request tag (fragment slot ID) passed through unchanged
CNT_W, 16, width of per-requester accept counters (wrapping)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  TEX0 texel available
req0_ready  out  1  TEX0 texel accepted this cycle
req0_texel  in  18  TEX0 RGBA5652: [17:13] R5, [12:7] G6, [6:2] B5, [1:0] A2
req0_tag  in  TAG_W  TEX0 tag
req1_valid  in  1  TEX1 texel available
req1_ready  out  1  TEX1 accepted
req1_texel  in  18  TEX1 RGBA5652
req1_tag  in  TAG_W  TEX1 tag
out_valid  out  1  promoted texel valid
out_ready  in  1  downstream accepts
out_src  out  1  0 = TEX0, 1 = TEX1
out_tag  out  TAG_W  tag of the output texel
out_r_q412  out  16  R channel, Q4.12, 0x0000..0x1000
out_g_q412  out  16  G channel, Q4.12
out_b_q412  out  16  B channel, Q4.12
out_a_q412  out  16  A channel, Q4.12
cnt0  out  CNT_W  count of TEX0 transfers accepted
cnt1  out  CNT_W  count of TEX1 transfers accepted

Behaviour:
- Reset (async assert, sync release): out_valid=0; out_src, out_tag, out_* channels=0; cnt0=cnt1=0; rr_last=1 (TEX0 has priority first); lock_valid=0. req*_ready=0 while rst_n=0.
- Promotion: combinational via fp_types_pkg promote_r5/g6/b5/a2_to_q412 on the muxed granted texel. It must be bit-exact with those functions. Result is registered into the output stage.
- can_accept = !out_valid | out_ready.
- Grant selection when lock_valid=0:
  - Only one requester valid: grant it.
  - Both valid: grant the requester != rr_last.
  - None valid: no grant.
- Grant never depends on out_ready or req*_ready, so there is no combinational loop. req_ready depends on out_ready combinationally.
- Lock: if a grant exists and can_accept=0, set lock_valid=1 and lock_id=granted. While locked, the grant stays at lock_id regardless of the other requester. The lock clears on the transfer cycle.
- Requester contract: valid, texel and tag are held stable until ready. The bench asserts this.
- reqN_ready = grant==N & can_accept & rst_n.
- Transfer (reqN_valid & reqN_ready):
  - Output register loads the promoted channels, out_tag = reqN_tag, out_src = N, out_valid=1.
  - rr_last=N.
  - cntN increments by 1, wrapping at 2^CNT_W.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 texel/cycle with out_ready held high. With both requesters continuously valid, grants alternate 0,1,0,1.
- Output held stable while out_valid & !out_ready.
- out_valid & out_ready with no new transfer: out_valid→0 next cycle; data registers may keep stale values.
- out_valid & out_ready with a simultaneous new transfer: output reloads, out_valid stays 1, no bubble.
- A requester dropping valid while locked is a contract violation; the lock persists until the transfer.
- Reset mid-operation: all state returns to reset values immediately and any in-flight texel is dropped.

Test Plan:
- Reset then single TEX0 request, texel 0x3FFFF, tag 0x5, out_ready=1 → req0_ready=1 in cycle 0. Next cycle: out_valid=1, r/g/b/a=0x1000, out_src=0, out_tag=0x5, cnt0=1.
- Texel 0x00000 on TEX1 → all channels 0x0000, out_src=1. Random texels are checked against the package functions.
- Both valid continuously for 8 cycles, out_ready=1 → out_src sequence 0,1,0,1,0,1,0,1; cnt0=cnt1=4.
- Output stall: out_ready=0 for 3 cycles while both valid, TEX1 granted at stall start → TEX1 stays locked, req0_ready=0, outputs stable. On out_ready=1, TEX1 transfers, then TEX0 next cycle.
- Back-to-back single requester, 5 texels, out_ready=1 → 5 consecutive out_valid cycles, no bubbles, correct tag order.
- Counter wrap with CNT_W=4: 17 TEX0 transfers → cnt0=1. Assert rst_n=0 mid-stall → out_valid=0 and counters=0 asynchronously.
